// File: rtl/mci_control_fsm_if.sv
// Fetch/decode bundle between the control sequencer and the datapath/instruction memory.
// The master side is the sequencer; the slave side is the datapath plus instruction memory.
interface mci_control_fsm_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      inst_i;
  logic             imem_ack_i;
  logic             zero_i;
  logic [31:0]      pc_o;
  logic             imem_req_o;
  logic [5:0]       op_code_o;
  logic [4:0]       rd_reg1_o;
  logic [4:0]       rd_reg2_o;
  logic [4:0]       wr_reg_o;
  logic             wr_enable_o;
  logic             halt_o;
  logic [CNT_W-1:0] retired_o;

  modport master (
    input  inst_i, imem_ack_i, zero_i,
    output pc_o, imem_req_o, op_code_o, rd_reg1_o, rd_reg2_o, wr_reg_o,
           wr_enable_o, halt_o, retired_o
  );

  modport slave (
    output inst_i, imem_ack_i, zero_i,
    input  pc_o, imem_req_o, op_code_o, rd_reg1_o, rd_reg2_o, wr_reg_o,
           wr_enable_o, halt_o, retired_o
  );
endinterface

// File: rtl/mci_control_fsm.sv
// Multicycle sequencer for the R-type/BEQ MIPS subset: owns PC and IR, fetches over
// req/ack, strobes the register-file write and resolves BEQ from the ALU zero flag.
module mci_control_fsm #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic clk,
  input  logic rst_n,
  mci_control_fsm_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_WB_R,
    S_BRANCH,
    S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  state_t           state_reg;
  logic [31:0]      pc_reg;
  logic [31:0]      pc4_reg;
  logic [31:0]      ir_reg;
  logic [CNT_W-1:0] retired_reg;
  logic             imem_req_reg;
  logic             wr_enable_reg;
  logic             halt_reg;

  logic [31:0] branch_off;
  assign branch_off = {{14{ir_reg[15]}}, ir_reg[15:0], 2'b00};

  // Outputs are registered alongside the state so they change in the same cycle the state does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_FETCH;
      pc_reg        <= RESET_PC;
      pc4_reg       <= 32'd0;
      ir_reg        <= 32'd0;
      retired_reg   <= '0;
      imem_req_reg  <= 1'b1;
      wr_enable_reg <= 1'b0;
      halt_reg      <= 1'b0;
    end else begin
      case (state_reg)
        S_FETCH: begin
          if (bus.imem_ack_i) begin
            ir_reg       <= bus.inst_i;
            pc4_reg      <= pc_reg + 32'd4;
            imem_req_reg <= 1'b0;
            state_reg    <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (ir_reg[31:26])
            OP_RTYPE: state_reg <= S_EXEC_R;
            OP_BEQ:   state_reg <= S_BRANCH;
            default: begin
              halt_reg  <= 1'b1;
              state_reg <= S_HALT;
            end
          endcase
        end
        S_EXEC_R: begin
          wr_enable_reg <= 1'b1;
          state_reg     <= S_WB_R;
        end
        S_WB_R: begin
          wr_enable_reg <= 1'b0;
          pc_reg        <= pc4_reg;
          retired_reg   <= retired_reg + CNT_W'(1);
          imem_req_reg  <= 1'b1;
          state_reg     <= S_FETCH;
        end
        S_BRANCH: begin
          pc_reg       <= bus.zero_i ? (pc4_reg + branch_off) : pc4_reg;
          retired_reg  <= retired_reg + CNT_W'(1);
          imem_req_reg <= 1'b1;
          state_reg    <= S_FETCH;
        end
        S_HALT: begin
          state_reg <= S_HALT;
        end
        default: begin
          imem_req_reg  <= 1'b1;
          wr_enable_reg <= 1'b0;
          state_reg     <= S_FETCH;
        end
      endcase
    end
  end

  assign bus.pc_o        = pc_reg;
  assign bus.imem_req_o  = imem_req_reg;
  assign bus.wr_enable_o = wr_enable_reg;
  assign bus.halt_o      = halt_reg;
  assign bus.retired_o   = retired_reg;

  // Field decode is combinational off IR, so fields hold until the next instruction latches.
  assign bus.op_code_o = ir_reg[31:26];
  assign bus.rd_reg1_o = ir_reg[25:21];
  assign bus.rd_reg2_o = ir_reg[20:16];
  assign bus.wr_reg_o  = (ir_reg[31:26] == OP_RTYPE) ? ir_reg[15:11] : 5'd0;

endmodule

// File: tb/tb_mci_control_fsm.sv
// Bench for mci_control_fsm: directed instruction sequence followed by random R-type/BEQ
// traffic, checked against an instruction-level model of PC, counter, latency and strobes.
module tb_mci_control_fsm;

  localparam int CNT_W = 16;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  // Instruction-level model state
  logic [31:0]      m_pc;
  logic [CNT_W-1:0] m_retired;
  logic [31:0]      m_prev_inst;

  mci_control_fsm_if #(.CNT_W(CNT_W)) bus ();

  mci_control_fsm #(
    .RESET_PC (32'h0000_0000),
    .CNT_W    (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic check_fields(input string tag, input logic [31:0] inst);
    logic [4:0] exp_wr;
    exp_wr = (inst[31:26] == 6'd0) ? inst[15:11] : 5'd0;
    check({tag, "_op"},  64'(bus.op_code_o), 64'(inst[31:26]));
    check({tag, "_rs"},  64'(bus.rd_reg1_o), 64'(inst[25:21]));
    check({tag, "_rt"},  64'(bus.rd_reg2_o), 64'(inst[20:16]));
    check({tag, "_wr"},  64'(bus.wr_reg_o),  64'(exp_wr));
  endtask

  function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] inst,
                                          input logic z);
    longint off;
    off = longint'($signed(inst[15:0]));
    if (inst[31:26] == 6'b000100 && z)
      return 32'(longint'(pc) + 4 + off * 4);
    return 32'(longint'(pc) + 4);
  endfunction

  task automatic reset_dut();
    rst_n = 1'b0;
    bus.imem_ack_i = 1'b0;
    bus.inst_i = 32'd0;
    bus.zero_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pc",      64'(bus.pc_o),        64'd0);
    check("rst_retired", 64'(bus.retired_o),   64'd0);
    check("rst_halt",    64'(bus.halt_o),      64'd0);
    check("rst_wren",    64'(bus.wr_enable_o), 64'd0);
    rst_n = 1'b1;
    m_pc = 32'd0;
    m_retired = '0;
    m_prev_inst = 32'd0;
    @(posedge clk);
    #1;
    check("rst_req_first", 64'(bus.imem_req_o), 64'd1);
    $display("[TB] reset released pc=%0h req=%0b", bus.pc_o, bus.imem_req_o);
  endtask

  // Runs one instruction starting in FETCH (#1 after an edge) with 'delay' stall cycles.
  task automatic run_instr(input logic [31:0] inst, input int delay, input logic z);
    int   cyc;
    int   wr_cnt;
    int   exp_lat;
    bit   is_r;
    is_r = (inst[31:26] == 6'd0);
    exp_lat = delay + (is_r ? 4 : 3);
    bus.zero_i = z;
    check("fetch_req", 64'(bus.imem_req_o), 64'd1);
    check("fetch_pc",  64'(bus.pc_o),       64'(m_pc));
    for (int d = 0; d < delay; d++) begin
      bus.imem_ack_i = 1'b0;
      bus.inst_i = $urandom;
      @(negedge clk);
      check("stall_req", 64'(bus.imem_req_o), 64'd1);
      check("stall_pc",  64'(bus.pc_o),       64'(m_pc));
      check_fields("stall", m_prev_inst);
      @(posedge clk);
      #1;
    end
    bus.imem_ack_i = 1'b1;
    bus.inst_i = inst;
    @(posedge clk);
    #1;
    cyc = 1 + delay;
    wr_cnt = 0;
    while (!bus.imem_req_o && cyc < exp_lat + 8) begin
      bus.imem_ack_i = 1'($urandom_range(0, 1));
      bus.inst_i = $urandom;
      check_fields("exec", inst);
      if (bus.wr_enable_o) wr_cnt++;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.imem_ack_i = 1'b0;
    m_pc = next_pc(m_pc, inst, z);
    m_retired = m_retired + CNT_W'(1);
    m_prev_inst = inst;
    check("latency",  64'(cyc),              64'(exp_lat));
    check("wr_pulse", 64'(wr_cnt),           64'(is_r ? 1 : 0));
    check("pc_next",  64'(bus.pc_o),         64'(m_pc));
    check("retired",  64'(bus.retired_o),    64'(m_retired));
    check("no_halt",  64'(bus.halt_o),       64'd0);
    $display("[TB] inst=%08h delay=%0d z=%0b cycles=%0d wr=%0d pc=%08h retired=%0d",
             inst, delay, z, cyc, wr_cnt, bus.pc_o, bus.retired_o);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.imem_ack_i = 1'b0;
    bus.inst_i = 32'd0;
    bus.zero_i = 1'b0;
    m_pc = 32'd0;
    m_retired = '0;
    m_prev_inst = 32'd0;

    reset_dut();
    check_fields("reset", 32'd0);

    // Directed: add, BEQ not taken / taken, backward branch, self-loop, stall
    run_instr(32'h0022_1820, 0, 1'b0);
    check("add_pc4", 64'(bus.pc_o), 64'd4);
    run_instr(32'h1022_0003, 0, 1'b0);
    check("beq_nt_pc", 64'(bus.pc_o), 64'd8);
    run_instr(32'h1022_FFFE, 0, 1'b1);
    check("beq_back_to4", 64'(bus.pc_o), 64'd4);
    run_instr(32'h1022_0003, 0, 1'b1);
    check("beq_t_pc", 64'(bus.pc_o), 64'd20);
    run_instr(32'h1022_FFFE, 0, 1'b1);
    check("beq_back_pc", 64'(bus.pc_o), 64'd16);
    for (int i = 0; i < 3; i++) begin
      run_instr(32'h1000_FFFF, i, 1'b1);
      check("self_loop_pc", 64'(bus.pc_o), 64'd16);
    end
    run_instr(32'h0043_2020, 3, 1'b0);

    // Random R-type / BEQ traffic
    for (int i = 0; i < 40; i++) begin
      logic [31:0] inst;
      bit          r;
      r = 1'($urandom_range(0, 1));
      inst = {r ? 6'b000000 : 6'b000100, 26'($urandom)};
      run_instr(inst, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Illegal opcode: halt two edges after the ack, then frozen
    bus.imem_ack_i = 1'b1;
    bus.inst_i = 32'h8C00_0000;
    @(posedge clk);
    #1;
    check("ill_decode_halt", 64'(bus.halt_o), 64'd0);
    bus.imem_ack_i = 1'b0;
    @(posedge clk);
    #1;
    check("ill_halt", 64'(bus.halt_o), 64'd1);
    for (int i = 0; i < 5; i++) begin
      bus.imem_ack_i = 1'($urandom_range(0, 1));
      bus.inst_i = $urandom;
      @(posedge clk);
      #1;
      check("halt_sticky",  64'(bus.halt_o),      64'd1);
      check("halt_req",     64'(bus.imem_req_o),  64'd0);
      check("halt_wren",    64'(bus.wr_enable_o), 64'd0);
      check("halt_pc",      64'(bus.pc_o),        64'(m_pc));
      check("halt_retired", 64'(bus.retired_o),   64'(m_retired));
      check("halt_wr_reg",  64'(bus.wr_reg_o),    64'd0);
    end
    $display("[TB] illegal opcode halted pc=%08h retired=%0d", bus.pc_o, bus.retired_o);

    // Reset mid-instruction (during EXEC_R)
    reset_dut();
    run_instr(32'h0022_1820, 0, 1'b0);
    bus.imem_ack_i = 1'b1;
    bus.inst_i = 32'h0085_3020;
    @(posedge clk);
    #1;
    bus.imem_ack_i = 1'b0;
    @(posedge clk);
    #1;
    check("midop_exec_wren", 64'(bus.wr_enable_o), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midop_pc",      64'(bus.pc_o),        64'd0);
    check("midop_retired", 64'(bus.retired_o),   64'd0);
    check("midop_wren",    64'(bus.wr_enable_o), 64'd0);
    check("midop_halt",    64'(bus.halt_o),      64'd0);
    check_fields("midop", 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midop_hold_wren", 64'(bus.wr_enable_o), 64'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_pc = 32'd0;
    m_retired = '0;
    m_prev_inst = 32'd0;
    #1;
    check("midop_req_after", 64'(bus.imem_req_o), 64'd1);
    $display("[TB] mid-op reset done pc=%08h", bus.pc_o);
    run_instr(32'h0022_1820, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
